// File: rtl/serial_adder_nbit.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_nbit
// Purpose : Bit-serial WIDTH-bit adder. One full-adder cell plus a carry flop
//           processes one bit per clock, LSB first, under a start/done
//           handshake. Optional subtract mode: SERIAL_ADDER_SUB_EN.
// Revision: 1.0 - initial release
// ============================================================================
module serial_adder_nbit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int              CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_a_sh_q,  w_a_sh_d;
    logic [WIDTH-1:0]   r_b_sh_q,  w_b_sh_d;
    logic [WIDTH-1:0]   r_acc_q,   w_acc_d;
    logic               r_carry_q, w_carry_d;
    logic [CNT_W-1:0]   r_cnt_q,   w_cnt_d;
    logic [WIDTH-1:0]   r_sum_q,   w_sum_d;
    logic               r_cout_q,  w_cout_d;
    logic               r_ovf_q,   w_ovf_d;
    logic               w_load_sub;
    logic               w_run_sub;
    logic               w_bit;
    logic               w_carry_nxt;

`ifdef SERIAL_ADDER_SUB_EN
    logic               r_sub_q,   w_sub_d;
    assign w_load_sub = sub;
    assign w_run_sub  = r_sub_q;
`else
    assign w_load_sub = 1'b0;
    assign w_run_sub  = 1'b0;
`endif

    assign w_bit       = r_a_sh_q[0] ^ r_b_sh_q[0] ^ r_carry_q;
    assign w_carry_nxt = (r_a_sh_q[0] & r_b_sh_q[0]) | (r_carry_q & (r_a_sh_q[0] ^ r_b_sh_q[0]));

    always_comb begin
        w_state_d = r_state_q;
        w_a_sh_d  = r_a_sh_q;
        w_b_sh_d  = r_b_sh_q;
        w_acc_d   = r_acc_q;
        w_carry_d = r_carry_q;
        w_cnt_d   = r_cnt_q;
        w_sum_d   = r_sum_q;
        w_cout_d  = r_cout_q;
        w_ovf_d   = r_ovf_q;
`ifdef SERIAL_ADDER_SUB_EN
        w_sub_d   = r_sub_q;
`endif
        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1, so cin is ignored in that mode
                    w_state_d = ST_SHIFT;
                    w_a_sh_d  = a;
                    w_b_sh_d  = w_load_sub ? ~b : b;
                    w_carry_d = w_load_sub ? 1'b1 : cin;
                    w_acc_d   = '0;
                    w_cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    w_sub_d   = sub;
`endif
                end
            end
            ST_SHIFT: begin
                w_a_sh_d  = r_a_sh_q >> 1;
                w_b_sh_d  = r_b_sh_q >> 1;
                w_acc_d   = {w_bit, r_acc_q[WIDTH-1:1]};
                w_carry_d = w_carry_nxt;
                w_cnt_d   = r_cnt_q + CNT_W'(1);
                if (r_cnt_q == C_CNT_LAST) begin
                    // r_carry_q is the carry into the MSB on this last step
                    w_state_d = ST_DONE;
                    w_sum_d   = {w_bit, r_acc_q[WIDTH-1:1]};
                    w_cout_d  = w_carry_nxt ^ w_run_sub;
                    w_ovf_d   = r_carry_q ^ w_carry_nxt;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_a_sh_q  <= '0;
            r_b_sh_q  <= '0;
            r_acc_q   <= '0;
            r_carry_q <= 1'b0;
            r_cnt_q   <= '0;
            r_sum_q   <= '0;
            r_cout_q  <= 1'b0;
            r_ovf_q   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub_q   <= 1'b0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_a_sh_q  <= w_a_sh_d;
            r_b_sh_q  <= w_b_sh_d;
            r_acc_q   <= w_acc_d;
            r_carry_q <= w_carry_d;
            r_cnt_q   <= w_cnt_d;
            r_sum_q   <= w_sum_d;
            r_cout_q  <= w_cout_d;
            r_ovf_q   <= w_ovf_d;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub_q   <= w_sub_d;
`endif
        end
    end

    assign busy     = (r_state_q == ST_SHIFT);
    assign done     = (r_state_q == ST_DONE);
    assign sum      = r_sum_q;
    assign cout     = r_cout_q;
    assign overflow = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_nbit.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_adder_nbit
// Purpose : Scoreboard bench for serial_adder_nbit (WIDTH=8) with an
//           arithmetic reference model and randomized operands.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_adder_nbit;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;
    int   n_done;
    int   cyc;

    serial_adder_nbit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic s);
        exp_t     e;
        int       full;
        if (!s) begin
            full   = int'(x) + int'(y) + int'(ci);
            e.sum  = WIDTH'(full);
            e.cout = (full >= (1 << WIDTH));
            e.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (e.sum[WIDTH-1] != x[WIDTH-1]);
        end else begin
            full   = int'(x) - int'(y);
            e.sum  = WIDTH'(full);
            e.cout = (x < y);
            e.ovf  = (x[WIDTH-1] != y[WIDTH-1]) && (e.sum[WIDTH-1] != x[WIDTH-1]);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy && done) chk("busy_and_done", 32'(busy & done), 32'd0);
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum",      32'(sum),      32'(e.sum));
                    chk("cout",     32'(cout),     32'(e.cout));
                    chk("overflow", 32'(overflow), 32'(e.ovf));
                end
            end
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy && !done) return;
        end
        chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Issue one operation; poke=1 pulses start with other operands in SHIFT and DONE
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic ci, input logic s, input bit poke);
        int  nbusy;
        bit  seen;
        int  d0;
        wait_idle();
        start = 1'b1;
        a = x;
        b = y;
        cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
        sub = s;
`endif
        exp_q.push_back(model(x, y, ci, s));
        @(posedge clk);
        #1;
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'($urandom);
`endif
        nbusy = 0;
        seen = 0;
        d0 = n_done;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) nbusy++;
            if (poke && nbusy == 3) begin
                start = 1'b1;
                a = 8'h11;
            end
            if (poke && nbusy == 4) start = 1'b0;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_cycles", 32'(nbusy), 32'(WIDTH));
        if (poke && seen) begin
            start = 1'b1;
            a = 8'h11;
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (busy) begin
                    chk("ignored_start_ran", 32'd1, 32'd0);
                    break;
                end
            end
            #1;
            chk("one_done_pulse", 32'(n_done - d0), 32'd1);
            chk("sum_stable", 32'(sum), 32'(model(x, y, ci, s).sum));
        end
    endtask

    initial begin
        int d0;
        int t_done[$];
        n_checks = 0;
        n_errors = 0;
        n_done   = 0;
        cyc      = 0;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        run_op(8'h3C, 8'h05, 1'b0, 1'b0, 1'b0);

        // Reset in the third SHIFT cycle of an operation that would set sum/cout
        wait_idle();
        start = 1'b1;
        a = 8'hFF;
        b = 8'h01;
        cin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        reset = 1'b0;
        d0 = n_done;
        repeat (15) @(negedge clk);
        #1;
        chk("midrst_no_done", 32'(n_done - d0), 32'd0);

        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b1, 1'b0, 1'b1);

        // Start held high: operations should complete every WIDTH+2 cycles
        wait_idle();
        start = 1'b1;
        a = 8'h10;
        b = 8'h20;
        cin = 1'b0;
        for (int k = 0; k < 3; k++) exp_q.push_back(model(8'h10, 8'h20, 1'b0, 1'b0));
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) begin
                t_done.push_back(k);
                if (t_done.size() == 3) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        chk("b2b_count", 32'(t_done.size()), 32'd3);
        if (t_done.size() == 3) begin
            chk("b2b_period1", 32'(t_done[1] - t_done[0]), 32'(WIDTH + 2));
            chk("b2b_period2", 32'(t_done[2] - t_done[1]), 32'(WIDTH + 2));
        end

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
`endif

        for (int n = 0; n < 20; n++) begin
            logic s;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), s, 1'b0);
        end

        repeat (15) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
